bus_cycle_arbiter: RTL

BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

---
 rtl/bus_cycle_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bus_cycle_arbiter.sv
// Two-requester round-robin arbiter driving a multiplexed ALE/RD/WR address-data bus.
// Latency: grant visible 1 clock after req in IDLE; full cycle STROBE_CYC+3 clocks; all outputs registered.
module bus_cycle_arbiter #(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic [1:0] req,
  input  logic [1:0] rnw,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] ad_in,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       ALE,
  output logic       rdb,
  output logic       wrb,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ADDR    = 5'b00010,
    STROBE  = 5'b00100,
    HOLD    = 5'b01000,
    RECOVER = 5'b10000
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYC - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       last_q;
  logic       rnw_q;
  logic [7:0] wdata_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic [7:0] rdata_q;
  logic       ale_q;
  logic       rdb_q;
  logic       wrb_q;
  logic [7:0] ad_out_q;
  logic       ad_oe_q;
  logic       win_d;

  // Winner index: on contention the requester not granted last time wins.
  always_comb win_d = (req == 2'b11) ? ~last_q : req[1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      rnw_q    <= 1'b0;
      wdata_q  <= 8'h00;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata_q  <= 8'h00;
      ale_q    <= 1'b0;
      rdb_q    <= 1'b1;
      wrb_q    <= 1'b1;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            state_q  <= ADDR;
            gnt_q    <= win_d ? 2'b10 : 2'b01;
            last_q   <= win_d;
            rnw_q    <= rnw[win_d];
            wdata_q  <= win_d ? wdata1 : wdata0;
            ad_out_q <= win_d ? addr1 : addr0;
            ale_q    <= 1'b1;
            ad_oe_q  <= 1'b1;
          end
        end
        ADDR: begin
          state_q <= STROBE;
          cnt_q   <= CNT_LOAD;
          ale_q   <= 1'b0;
          if (rnw_q) begin
            rdb_q   <= 1'b0;
            ad_oe_q <= 1'b0;
          end else begin
            wrb_q    <= 1'b0;
            ad_out_q <= wdata_q;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= HOLD;
            rdb_q   <= 1'b1;
            wrb_q   <= 1'b1;
            if (rnw_q) rdata_q <= ad_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          state_q <= RECOVER;
          ad_oe_q <= 1'b0;
          done_q  <= gnt_q;
        end
        RECOVER: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          ale_q   <= 1'b0;
          rdb_q   <= 1'b1;
          wrb_q   <= 1'b1;
          ad_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign ALE    = ale_q;
  assign rdb    = rdb_q;
  assign wrb    = wrb_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;

endmodule
